uart_frame_loader: RTL and testbench

UART_FRAME_LOADER -- requirements
Module: uart_frame_loader

---
 rtl/uart_frame_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_frame_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Receives a sync-prefixed pixel frame from a UART, writes it into a pixel buffer,
// verifies a trailing mod-256 checksum and hands the buffer to the consumer.
//
// state | meaning
// SYNC  | hunting for SYNC_BYTE, all other bytes dropped
// LOAD  | writing N_PIXELS bytes into the buffer, summing them
// CHECK | waiting for the checksum byte
// READY | good frame held, receiver gated off until frame_ack
// ERROR | one-cycle abort pulse, then back to SYNC
module uart_frame_loader #(
  parameter int         N_PIXELS       = 784,
  parameter int         ADDR_W         = 10,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              rx_en,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_wdata,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [7:0]        frame_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIXELS - 1);
  // Idle timer is a down-counter; it is reloaded on every accepted byte and
  // aborts the frame when it has run out on an idle cycle.
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_BRK = 2'b10;
  localparam logic [1:0] ERR_SUM = 2'b11;

  typedef enum logic [2:0] {
    S_SYNC,
    S_LOAD,
    S_CHECK,
    S_READY,
    S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        pix_wdata_q, pix_wdata_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic byte_ok;
  logic byte_brk;
  logic tmo_hit;

  assign byte_ok  = rx_valid & ~rx_break;
  assign byte_brk = rx_valid & rx_break;
  assign tmo_hit  = (tmo_q == 32'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_SYNC;
      cnt_q       <= '0;
      csum_q      <= 8'd0;
      tmo_q       <= TMO_LOAD;
      pix_we_q    <= 1'b0;
      pix_addr_q  <= '0;
      pix_wdata_q <= 8'd0;
      err_code_q  <= 2'b00;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      pix_we_q    <= pix_we_d;
      pix_addr_q  <= pix_addr_d;
      pix_wdata_q <= pix_wdata_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    pix_we_d    = 1'b0;
    pix_addr_d  = pix_addr_q;
    pix_wdata_d = pix_wdata_q;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      S_SYNC: begin
        if (byte_ok && (rx_data == SYNC_BYTE)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          csum_d  = 8'd0;
          tmo_d   = TMO_LOAD;
        end
      end

      S_LOAD: begin
        if (byte_brk) begin
          state_d    = S_ERROR;
          err_code_d = ERR_BRK;
        end else if (byte_ok) begin
          pix_we_d    = 1'b1;
          pix_addr_d  = cnt_q[ADDR_W-1:0];
          pix_wdata_d = rx_data;
          cnt_d       = cnt_q + 1'b1;
          csum_d      = csum_q + rx_data;
          tmo_d       = TMO_LOAD;
          if (cnt_q == LAST_IDX) begin
            state_d = S_CHECK;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end

      S_CHECK: begin
        if (byte_brk) begin
          state_d    = S_ERROR;
          err_code_d = ERR_BRK;
        end else if (byte_ok) begin
          if (rx_data == csum_q) begin
            state_d     = S_READY;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            state_d    = S_ERROR;
            err_code_d = ERR_SUM;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo_q - 32'd1;
        end
      end

      S_READY: begin
        if (frame_ack) begin
          state_d = S_SYNC;
        end
      end

      S_ERROR: begin
        state_d = S_SYNC;
      end

      default: begin
        state_d = S_SYNC;
      end
    endcase
  end

  assign rx_en       = (state_q != S_READY);
  assign frame_ready = (state_q == S_READY);
  assign frame_err   = (state_q == S_ERROR);
  assign pix_we      = pix_we_q;
  assign pix_addr    = pix_addr_q;
  assign pix_wdata   = pix_wdata_q;
  assign err_code    = err_code_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboarded bench for uart_frame_loader with N_PIXELS=4, TIMEOUT_CYCLES=100:
// stimulus queues expected writes/aborts/ready events, a monitor pops and compares them.
module tb_uart_frame_loader;

  localparam int ADDR_W = 10;
  localparam logic [1:0] EV_WR  = 2'd0;
  localparam logic [1:0] EV_ERR = 2'd1;
  localparam logic [1:0] EV_RDY = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_break;
  logic              rx_en;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_wdata;
  logic              frame_ready;
  logic              frame_ack;
  logic              frame_err;
  logic [1:0]        err_code;
  logic [7:0]        frame_cnt;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic rdy_prev = 1'b0;

  uart_frame_loader #(
    .N_PIXELS(4),
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_break(rx_break),
    .rx_en(rx_en),
    .pix_we(pix_we),
    .pix_addr(pix_addr),
    .pix_wdata(pix_wdata),
    .frame_ready(frame_ready),
    .frame_ack(frame_ack),
    .frame_err(frame_err),
    .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b,
                           input string nm);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event a=%0h b=%0h, expected no event", nm, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b) begin
        n_bad++;
        $display("FAIL %s: got kind=%0d a=%0h b=%0h, expected kind=%0d a=%0h b=%0h",
                 nm, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (pix_we) expect_ev(EV_WR, 16'(pix_addr), 16'(pix_wdata), "pix_write");
    if (frame_err) expect_ev(EV_ERR, 16'(err_code), 16'd0, "frame_err");
    if (frame_ready && !rdy_prev) expect_ev(EV_RDY, 16'(frame_cnt), 16'd0, "frame_ready");
    rdy_prev = frame_ready;
  end

  task automatic push(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic brk);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_break = brk;
    tick(1);
    rx_valid = 1'b0;
    rx_break = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int budget, input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected events still pending, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic good_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] fc);
    logic [7:0] px[4];
    logic [7:0] sum;
    px[0] = b0; px[1] = b1; px[2] = b2; px[3] = b3;
    sum = 8'd0;
    send(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      push(EV_WR, 16'(i), 16'(px[i]));
      sum = sum + px[i];
      send(px[i], 1'b0);
    end
    push(EV_RDY, 16'(fc), 16'd0);
    send(sum, 1'b0);
    drain(20, "good_frame");
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    check("ack_ready_low", 32'(frame_ready), 32'd0);
    check("ack_rx_en", 32'(rx_en), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_en"}, 32'(rx_en), 32'd1);
    check({tag, "_pix_we"}, 32'(pix_we), 32'd0);
    check({tag, "_pix_addr"}, 32'(pix_addr), 32'd0);
    check({tag, "_pix_wdata"}, 32'(pix_wdata), 32'd0);
    check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    rx_break  = 1'b0;
    frame_ack = 1'b0;
    tick(3);
    check_reset_vals("rst");
    resetn = 1'b1;
    tick(1);

    // Good frame, then a byte during READY that must be ignored
    good_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'd1);
    check("rdy_frame_ready", 32'(frame_ready), 32'd1);
    check("rdy_rx_en", 32'(rx_en), 32'd0);
    check("rdy_frame_cnt", 32'(frame_cnt), 32'd1);
    send(8'hA5, 1'b0);
    tick(3);
    check("rdy_hold", 32'(frame_ready), 32'd1);
    ack();

    // Leading junk dropped, bad checksum aborts
    send(8'h00, 1'b0);
    send(8'h17, 1'b0);
    send(8'hA5, 1'b0);
    push(EV_WR, 16'd0, 16'h10); send(8'h10, 1'b0);
    push(EV_WR, 16'd1, 16'h20); send(8'h20, 1'b0);
    push(EV_WR, 16'd2, 16'h30); send(8'h30, 1'b0);
    push(EV_WR, 16'd3, 16'h40); send(8'h40, 1'b0);
    push(EV_ERR, 16'd3, 16'd0);
    send(8'h99, 1'b0);
    drain(10, "csum_err");
    check("csum_err_code", 32'(err_code), 32'd3);
    check("csum_not_ready", 32'(frame_ready), 32'd0);
    check("csum_frame_cnt", 32'(frame_cnt), 32'd1);

    // Idle timeout mid-frame, then recovery
    send(8'hA5, 1'b0);
    push(EV_WR, 16'd0, 16'h01); send(8'h01, 1'b0);
    push(EV_WR, 16'd1, 16'h02); send(8'h02, 1'b0);
    drain(5, "tmo_writes");
    push(EV_ERR, 16'd1, 16'd0);
    tick(94);
    check("tmo_not_early", 32'(exp_q.size()), 32'd1);
    drain(30, "tmo_err");
    check("tmo_err_code", 32'(err_code), 32'd1);
    good_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'd2);
    ack();

    // Break in LOAD aborts without writing
    send(8'hA5, 1'b0);
    push(EV_WR, 16'd0, 16'h05); send(8'h05, 1'b0);
    push(EV_ERR, 16'd2, 16'd0);
    send(8'h00, 1'b1);
    drain(10, "brk_err");
    tick(5);
    check("brk_err_code_hold", 32'(err_code), 32'd2);

    // frame_ack in SYNC is ignored
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
    tick(1);
    check("ack_sync_cnt", 32'(frame_cnt), 32'd2);
    check("ack_sync_rx_en", 32'(rx_en), 32'd1);

    // Reset mid-frame: clean state, no abort pulse, partial frame dropped
    send(8'hA5, 1'b0);
    push(EV_WR, 16'd0, 16'h05); send(8'h05, 1'b0);
    drain(5, "pre_rst_write");
    resetn = 1'b0;
    tick(1);
    check_reset_vals("midrst");
    resetn = 1'b1;
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    tick(3);
    drain(1, "post_rst_quiet");

    // 256 good frames wrap the counter to zero
    for (int f = 1; f <= 256; f++) begin
      logic [7:0] base;
      base = 8'(f * 3);
      good_frame(base, base + 8'd1, base + 8'd7, base ^ 8'h5A, 8'(f));
      ack();
    end
    check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    tick(2);
    drain(1, "final_queue");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
